// File: rtl/inst_stream_buffer_if.sv
// Probe, flush and memory-port bundle for the instruction stream buffer.
// The buffer itself uses the slave modport; the cache/memory side uses master.
interface inst_stream_buffer_if #(
  parameter int DEPTH      = 4,
  parameter int LINE_SIZE  = 256,
  parameter int ADDR_WIDTH = 32
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic                  lookup_valid;
  logic [ADDR_WIDTH-1:0] lookup_addr;
  logic                  lookup_hit;
  logic [LINE_SIZE-1:0]  lookup_rdata;
  logic                  flush;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic                  mem_rvalid;
  logic [LINE_SIZE-1:0]  mem_rdata;
  logic [OCC_W-1:0]      occupancy;

  modport slave (
    input  lookup_valid, lookup_addr, flush, mem_ack, mem_rvalid, mem_rdata,
    output lookup_hit, lookup_rdata, mem_req, mem_addr, occupancy
  );

  modport master (
    output lookup_valid, lookup_addr, flush, mem_ack, mem_rvalid, mem_rdata,
    input  lookup_hit, lookup_rdata, mem_req, mem_addr, occupancy
  );
endinterface

// File: rtl/inst_stream_buffer.sv
// Multi-entry next-line instruction prefetcher. Buffered lines sit in a
// circular FIFO; a demand miss restarts a sequential stream that fetches one
// line at a time over a shared cacheline port.
module inst_stream_buffer #(
  parameter int DEPTH        = 4,
  parameter int LINE_SIZE    = 256,
  parameter int ADDR_WIDTH   = 32,
  parameter int STRIDE_LINES = 1,
  parameter int PAGE_STOP    = 1
) (
  input logic                clk,
  input logic                rst,
  inst_stream_buffer_if.slave bus
);
  localparam int LB     = LINE_SIZE / 8;
  localparam int OFF_W  = $clog2(LB);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int OCC_W  = PTR_W + 1;
  localparam int LN_W   = ADDR_WIDTH - OFF_W;
  localparam int PAGE_W = ADDR_WIDTH - 12;
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(STRIDE_LINES * LB);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DROP  = 2'd3;

  logic [LN_W-1:0]       tag_r [DEPTH];
  logic [LINE_SIZE-1:0]  data_r [DEPTH];
  logic [PTR_W-1:0]      head_r, tail_r;
  logic [OCC_W-1:0]      occ_r;
  logic [1:0]            state_r;
  logic                  stale_r, stream_active_r, mem_req_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r, next_fetch_r;
  logic [PAGE_W-1:0]     origin_page_r;

  logic                  found_s;
  logic [PTR_W-1:0]      match_off_s, match_idx_s, idx_s;
  logic [LN_W-1:0]       probe_ln_s;
  logic                  hit_s, miss_s, restart_s, clear_s, pop_s, fill_s;
  logic                  page_ok_s, can_issue_s;
  logic [ADDR_WIDTH-1:0] restart_fetch_s;
  logic [PTR_W-1:0]      head_nx_s, tail_nx_s;
  logic [OCC_W-1:0]      occ_nx_s;
  logic                  unused_bits_s;

  // Search valid entries in FIFO order from head; the oldest match wins.
  always_comb begin
    found_s     = 1'b0;
    match_off_s = '0;
    match_idx_s = head_r;
    idx_s       = head_r;
    probe_ln_s  = bus.lookup_addr[ADDR_WIDTH-1:OFF_W];
    for (int k = 0; k < DEPTH; k++) begin
      idx_s = head_r + PTR_W'(k);
      if (!found_s && (OCC_W'(k) < occ_r) && (tag_r[idx_s] == probe_ln_s)) begin
        found_s     = 1'b1;
        match_off_s = PTR_W'(k);
        match_idx_s = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign hit_s     = bus.lookup_valid & found_s;
  assign miss_s    = bus.lookup_valid & ~found_s;
  assign restart_s = miss_s & ~bus.flush;
  assign clear_s   = bus.flush | miss_s;
  assign pop_s     = hit_s & ~bus.flush;
  // A fill that coincides with a miss or flush is thrown away with the rest.
  assign fill_s    = (state_r == S_WAIT) & bus.mem_rvalid & ~clear_s;

  assign restart_fetch_s = {probe_ln_s, {OFF_W{1'b0}}} + STEP;
  assign page_ok_s   = (PAGE_STOP == 0) || (next_fetch_r[ADDR_WIDTH-1:12] == origin_page_r);
  // A clear in the same cycle suppresses the issue: the fetch address is about to change.
  assign can_issue_s = stream_active_r & (occ_r < OCC_W'(DEPTH)) & page_ok_s & ~clear_s;

  assign bus.lookup_hit   = hit_s;
  assign bus.lookup_rdata = hit_s ? data_r[match_idx_s] : '0;
  assign bus.mem_req      = mem_req_r;
  assign bus.mem_addr     = mem_addr_r;
  assign bus.occupancy    = occ_r;
  assign unused_bits_s    = ^bus.lookup_addr[OFF_W-1:0];

  // Next head/tail/occupancy from pop, fill and clear.
  always_comb begin
    head_nx_s = head_r;
    tail_nx_s = tail_r;
    occ_nx_s  = occ_r;
    if (clear_s) begin
      head_nx_s = '0;
      tail_nx_s = '0;
      occ_nx_s  = '0;
    end else begin
      if (pop_s) begin
        head_nx_s = head_r + match_off_s + PTR_W'(1);
        occ_nx_s  = occ_nx_s - (OCC_W'(match_off_s) + OCC_W'(1));
      end else begin
        head_nx_s = head_r;
      end
      if (fill_s) begin
        tail_nx_s = tail_r + PTR_W'(1);
        occ_nx_s  = occ_nx_s + OCC_W'(1);
      end else begin
        tail_nx_s = tail_r;
      end
    end
  end

  // Line storage; contents are only meaningful below occupancy, so no reset.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      data_r[tail_r] <= bus.mem_rdata;
    end
  end

  // Tags, FIFO pointers, stream tracking and the fetch FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) tag_r[k] <= '0;
      head_r          <= '0;
      tail_r          <= '0;
      occ_r           <= '0;
      state_r         <= S_IDLE;
      stale_r         <= 1'b0;
      stream_active_r <= 1'b0;
      mem_req_r       <= 1'b0;
      mem_addr_r      <= '0;
      next_fetch_r    <= '0;
      origin_page_r   <= '0;
    end else begin
      head_r <= head_nx_s;
      tail_r <= tail_nx_s;
      occ_r  <= occ_nx_s;
      if (fill_s) begin
        tag_r[tail_r] <= mem_addr_r[ADDR_WIDTH-1:OFF_W];
      end

      // Stream origin and fetch pointer. A stale ack belongs to an abandoned
      // stream and must not skip the first line of the new one.
      if (bus.flush) begin
        stream_active_r <= 1'b0;
      end else if (restart_s) begin
        stream_active_r <= 1'b1;
        next_fetch_r    <= restart_fetch_s;
        origin_page_r   <= bus.lookup_addr[ADDR_WIDTH-1:12];
      end else if ((state_r == S_IDLE) && stream_active_r && !page_ok_s) begin
        stream_active_r <= 1'b0;
      end else if ((state_r == S_ISSUE) && bus.mem_ack && !stale_r) begin
        next_fetch_r <= next_fetch_r + STEP;
      end else begin
        stream_active_r <= stream_active_r;
      end

      case (state_r)
        S_IDLE: begin
          if (can_issue_s) begin
            state_r    <= S_ISSUE;
            mem_req_r  <= 1'b1;
            mem_addr_r <= next_fetch_r;
            stale_r    <= 1'b0;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (bus.mem_ack) begin
            mem_req_r <= 1'b0;
            stale_r   <= 1'b0;
            state_r   <= (stale_r || clear_s) ? S_DROP : S_WAIT;
          end else if (clear_s) begin
            stale_r <= 1'b1;
          end else begin
            stale_r <= stale_r;
          end
        end
        S_WAIT: begin
          if (bus.mem_rvalid) begin
            state_r <= S_IDLE;
          end else if (clear_s) begin
            state_r <= S_DROP;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_DROP: begin
          if (bus.mem_rvalid) begin
            state_r <= S_IDLE;
            stale_r <= 1'b0;
          end else begin
            state_r <= S_DROP;
          end
        end
        default: begin
          state_r   <= S_IDLE;
          mem_req_r <= 1'b0;
          stale_r   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_inst_stream_buffer.sv
// Self-checking bench for inst_stream_buffer: a line-granular model of the
// buffer contents, stream pointer and outstanding request, plus a memory responder.
module tb_inst_stream_buffer;
  localparam int DEPTH = 4;
  localparam int LSZ   = 256;
  localparam int AW    = 32;
  localparam int LB    = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_stream_buffer_if #(.DEPTH(DEPTH), .LINE_SIZE(LSZ), .ADDR_WIDTH(AW)) bus ();

  inst_stream_buffer #(.DEPTH(DEPTH), .LINE_SIZE(LSZ), .ADDR_WIDTH(AW),
                       .STRIDE_LINES(1), .PAGE_STOP(1))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Model: buffered lines oldest first, stream state, outstanding request.
  logic [31:0]    q_addr[$];
  bit             m_stream;
  logic [31:0]    m_nf;
  logic [19:0]    m_origin;
  bit             m_inflight, m_acked, m_stale;
  logic [31:0]    m_req_addr;
  bit             resp_pending;
  int             resp_delay;
  logic [31:0]    req_log[$];
  int             ack_pct = 100;
  int             rv_max = 2;
  bit             hold_rv = 0;
  bit             last_hit;
  logic [LSZ-1:0] last_rdata;

  function automatic logic [LSZ-1:0] line_data(input logic [31:0] a);
    return {4{a, a ^ 32'hDEAD_BEEF}};
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return (a / LB) * LB;
  endfunction

  task automatic model_reset();
    q_addr.delete();
    m_stream = 0; m_nf = '0; m_origin = '0;
    m_inflight = 0; m_acked = 0; m_stale = 0; m_req_addr = '0;
    resp_pending = 0; resp_delay = 0;
  endtask

  // One clock: drive at posedge+1, check at negedge, update model at posedge, check occupancy.
  task automatic cycle(input bit lv, input logic [31:0] la, input bit fl);
    bit ack, rv, found, clr, fill;
    int idx;
    ack = bus.mem_req && !m_acked && ($urandom_range(0, 99) < ack_pct);
    rv  = resp_pending && (resp_delay == 0) && !hold_rv;
    bus.lookup_valid = lv; bus.lookup_addr = la; bus.flush = fl;
    bus.mem_ack = ack; bus.mem_rvalid = rv;
    bus.mem_rdata = rv ? line_data(m_req_addr) : '0;
    found = 0; idx = 0;
    foreach (q_addr[i]) if (!found && q_addr[i] == line_of(la)) begin found = 1; idx = i; end
    #4;
    last_hit = bus.lookup_hit; last_rdata = bus.lookup_rdata;
    checks++;
    if (bus.lookup_hit !== (lv && found)) begin
      failures++; $display("FAIL lookup_hit addr=%h got=%b exp=%b", la, bus.lookup_hit, lv && found);
    end
    if (lv && found) begin
      checks++;
      if (bus.lookup_rdata !== line_data(q_addr[idx])) begin
        failures++; $display("FAIL lookup_rdata addr=%h got=%h exp=%h", la, bus.lookup_rdata, line_data(q_addr[idx]));
      end
    end
    if (bus.mem_req) begin
      checks++;
      if (!m_inflight) begin
        if (bus.mem_addr !== m_nf || !m_stream || q_addr.size() >= DEPTH || m_nf[31:12] != m_origin) begin
          failures++; $display("FAIL req_issue got=%h exp=%h stream=%0d occ=%0d", bus.mem_addr, m_nf, m_stream, q_addr.size());
        end
        m_inflight = 1; m_acked = 0; m_stale = 0; m_req_addr = bus.mem_addr;
        req_log.push_back(bus.mem_addr);
      end else if (m_acked) begin
        failures++; $display("FAIL req_overlap got=%h while %h outstanding", bus.mem_addr, m_req_addr);
      end else if (bus.mem_addr !== m_req_addr) begin
        failures++; $display("FAIL req_hold got=%h exp=%h", bus.mem_addr, m_req_addr);
      end
    end
    @(posedge clk);
    clr = fl || (lv && !found);
    if (m_inflight && clr) m_stale = 1;
    fill = rv && !m_stale;
    if (fl) begin
      q_addr.delete(); m_stream = 0;
    end else if (lv && !found) begin
      q_addr.delete(); m_stream = 1;
      m_nf = line_of(la) + LB; m_origin = la[31:12];
    end else if (lv && found) begin
      repeat (idx + 1) void'(q_addr.pop_front());
    end
    if (fill) q_addr.push_back(m_req_addr);
    if (ack) begin
      m_acked = 1; resp_pending = 1; resp_delay = $urandom_range(0, rv_max);
      if (!m_stale) m_nf = m_nf + LB;
    end
    if (rv) begin
      m_inflight = 0; m_acked = 0; m_stale = 0; resp_pending = 0;
    end else if (resp_pending && !ack && resp_delay > 0) begin
      resp_delay--;
    end
    #1;
    checks++;
    if (bus.occupancy !== 3'(q_addr.size())) begin
      failures++; $display("FAIL occupancy got=%0d exp=%0d", bus.occupancy, q_addr.size());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0);
  endtask

  // Assert reset away from the edge and check outputs drop immediately.
  task automatic apply_async_reset();
    #1 rst = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.occupancy !== 3'd0 || bus.mem_addr !== 32'h0) begin
      failures++; $display("FAIL async_reset req=%b occ=%0d addr=%h exp=0/0/0", bus.mem_req, bus.occupancy, bus.mem_addr);
    end
    bus.mem_ack = 0; bus.mem_rvalid = 0; bus.lookup_valid = 0; bus.flush = 0;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; model_reset();
    bus.lookup_valid = 1; bus.lookup_addr = 32'h0; bus.flush = 0;
    bus.mem_ack = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
    #3;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || bus.occupancy !== 3'd0 || bus.lookup_hit !== 1'b0) begin
      failures++; $display("FAIL reset_state req=%b addr=%h occ=%0d hit=%b exp=0", bus.mem_req, bus.mem_addr, bus.occupancy, bus.lookup_hit);
    end
    @(posedge clk); #1 rst = 1'b1;
    idle(3);
  endtask

  task automatic test_stream_fill();
    int n0;
    n0 = req_log.size();
    cycle(1'b1, 32'h0000_1000, 1'b0);
    idle(40);
    checks++;
    if (req_log.size() - n0 != 4) begin
      failures++; $display("FAIL fill_req_count got=%0d exp=4", req_log.size() - n0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (req_log[n0 + i] !== 32'h1020 + 32'(i) * 32'h20) begin
          failures++; $display("FAIL fill_req_addr idx=%0d got=%h exp=%h", i, req_log[n0 + i], 32'h1020 + 32'(i) * 32'h20);
        end
      end
    end
    checks++;
    if (bus.occupancy !== 3'd4 || bus.mem_req !== 1'b0) begin
      failures++; $display("FAIL full_stop occ=%0d req=%b exp=4/0", bus.occupancy, bus.mem_req);
    end
  endtask

  task automatic test_hit_pop();
    int n0;
    n0 = req_log.size();
    cycle(1'b1, 32'h0000_1044, 1'b0);
    checks++;
    if (last_hit !== 1'b1 || last_rdata !== line_data(32'h1040)) begin
      failures++; $display("FAIL hit_pop_data hit=%b got=%h exp=%h", last_hit, last_rdata, line_data(32'h1040));
    end
    checks++;
    if (bus.occupancy !== 3'd2) begin
      failures++; $display("FAIL hit_pop_occ got=%0d exp=2", bus.occupancy);
    end
    idle(30);
    checks++;
    if (req_log.size() <= n0 || req_log[n0] !== 32'h10A0) begin
      failures++; $display("FAIL hit_pop_next_req got=%h exp=000010a0", (req_log.size() > n0) ? req_log[n0] : 32'hFFFF_FFFF);
    end
  endtask

  task automatic test_drop();
    int n0, t;
    cycle(1'b0, 32'h0, 1'b1);
    idle(10);
    cycle(1'b1, 32'h0000_1000, 1'b0);
    t = 0;
    while (!(m_acked && m_req_addr == 32'h1060) && t < 200) begin
      if (q_addr.size() == 2) hold_rv = 1;
      cycle(1'b0, 32'h0, 1'b0); t++;
    end
    checks++;
    if (t >= 200) begin failures++; $display("FAIL drop_setup timeout waiting for 00001060"); end
    n0 = req_log.size();
    cycle(1'b1, 32'h0000_2000, 1'b0);
    checks++;
    if (bus.occupancy !== 3'd0) begin
      failures++; $display("FAIL drop_occ got=%0d exp=0", bus.occupancy);
    end
    hold_rv = 0;
    idle(20);
    checks++;
    if (req_log.size() <= n0 || req_log[n0] !== 32'h2020) begin
      failures++; $display("FAIL drop_next_req got=%h exp=00002020", (req_log.size() > n0) ? req_log[n0] : 32'hFFFF_FFFF);
    end
    cycle(1'b1, 32'h0000_2020, 1'b0);
    checks++;
    if (last_hit !== 1'b1 || last_rdata !== line_data(32'h2020)) begin
      failures++; $display("FAIL drop_refill hit=%b got=%h exp=%h", last_hit, last_rdata, line_data(32'h2020));
    end
  endtask

  task automatic test_page_stop();
    int n0;
    cycle(1'b0, 32'h0, 1'b1);
    idle(10);
    n0 = req_log.size();
    cycle(1'b1, 32'h0000_1FC0, 1'b0);
    idle(30);
    checks++;
    if (req_log.size() - n0 != 1 || req_log[n0] !== 32'h1FE0) begin
      failures++; $display("FAIL page_stop reqs=%0d first=%h exp=1/00001fe0", req_log.size() - n0,
                           (req_log.size() > n0) ? req_log[n0] : 32'hFFFF_FFFF);
    end
    checks++;
    if (bus.occupancy !== 3'd1 || bus.mem_req !== 1'b0) begin
      failures++; $display("FAIL page_stop_idle occ=%0d req=%b exp=1/0", bus.occupancy, bus.mem_req);
    end
  endtask

  task automatic test_hit_fill();
    int t;
    cycle(1'b0, 32'h0, 1'b1);
    idle(10);
    cycle(1'b1, 32'h0000_3000, 1'b0);
    t = 0;
    while (!(m_acked && q_addr.size() == 3) && t < 200) begin
      if (q_addr.size() == 3) hold_rv = 1;
      cycle(1'b0, 32'h0, 1'b0); t++;
    end
    checks++;
    if (t >= 200) begin failures++; $display("FAIL hit_fill_setup timeout"); end
    hold_rv = 0; resp_delay = 0;
    cycle(1'b1, 32'h0000_3020, 1'b0);
    checks++;
    if (bus.occupancy !== 3'd3) begin
      failures++; $display("FAIL hit_fill_occ got=%0d exp=3", bus.occupancy);
    end
    cycle(1'b1, 32'h0000_3080, 1'b0);
    checks++;
    if (last_hit !== 1'b1 || last_rdata !== line_data(32'h3080)) begin
      failures++; $display("FAIL hit_fill_tail hit=%b got=%h exp=%h", last_hit, last_rdata, line_data(32'h3080));
    end
  endtask

  task automatic test_async_reset();
    int t;
    cycle(1'b0, 32'h0, 1'b1);
    idle(10);
    ack_pct = 0;
    cycle(1'b1, 32'h0000_4000, 1'b0);
    t = 0;
    while (!m_inflight && t < 20) begin cycle(1'b0, 32'h0, 1'b0); t++; end
    checks++;
    if (t >= 20) begin failures++; $display("FAIL reset_setup no request seen"); end
    apply_async_reset();
    ack_pct = 100;
    cycle(1'b1, 32'h0000_4020, 1'b0);
    checks++;
    if (last_hit !== 1'b0) begin
      failures++; $display("FAIL reset_probe hit=%b exp=0", last_hit);
    end
    idle(20);
  endtask

  task automatic test_random();
    bit lv, fl;
    logic [31:0] la;
    ack_pct = 60; rv_max = 3;
    for (int i = 0; i < 800; i++) begin
      lv = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 49) == 0);
      la = 32'h5000 + 32'($urandom_range(0, 15)) * 32'h20 + 32'($urandom_range(0, 31));
      cycle(lv, la, fl);
    end
    ack_pct = 100; rv_max = 2;
    idle(20);
  endtask

  initial begin
    test_reset();
    test_stream_fill();
    test_hit_pop();
    test_drop();
    test_page_stop();
    test_hit_fill();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inst_stream_buffer.md
Name: inst_stream_buffer

Overview:
- Parametrised multi-entry next-line instruction prefetcher. It generalises the single-line prefetch of the current instruction cache.
- Sits beside the instruction cache. On a demand miss, the cache presents the address. The block returns a buffered line (hit) or restarts a sequential stream. Lines are fetched over a shared cacheline memory port.
- Holds up to DEPTH lines in a circular FIFO, with configurable stride and optional page-boundary stop.

Parameters:
- DEPTH, 4, number of line entries (power of 2, >=2)
- LINE_SIZE, 256, cacheline width in bits (power of 2); line bytes LB = LINE_SIZE/8
- ADDR_WIDTH, 32, byte address width
- STRIDE_LINES, 1, lines advanced per prefetch (>=1)
- PAGE_STOP, 1, 1 = never prefetch across a 4 KiB boundary

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- lookup_valid  in  1  cache demand-miss probe
- lookup_addr  in  ADDR_WIDTH  probe byte address (offset bits ignored)
- lookup_hit  out  1  combinational: probe matches a valid entry
- lookup_rdata  out  LINE_SIZE  matching line; 'x when lookup_hit=0
- flush  in  1  invalidate all entries, stop stream
- mem_req  out  1  line read request
- mem_addr  out  ADDR_WIDTH  line-aligned request address
- mem_ack  in  1  request accepted
- mem_rvalid  in  1  read data valid (one per accepted request)
- mem_rdata  in  LINE_SIZE  read line
- occupancy  out  $clog2(DEPTH)+1  valid entry count

Behaviour:
- Reset (async, rst=0):
  - all entries invalid; head=tail=0; occupancy=0
  - state IDLE; mem_req=0; mem_addr=0; stream_active=0; next_fetch=0
- Line number: LN(a) = a >> log2(LB). Entry tag = LN of its fetch address.
- Lookup (same cycle, combinational):
  - lookup_hit=1 iff lookup_valid and some valid entry i has tag==LN(lookup_addr).
  - Search is in FIFO order from head; the first match wins. lookup_rdata = that entry's data.
  - Next edge on hit: entries head..i are popped and occupancy decreases by the popped count. The stream continues.
  - Next edge on miss (lookup_valid=1, lookup_hit=0): all entries are invalidated and stream_active=1. next_fetch = (LN(lookup_addr)+STRIDE_LINES)*LB, modulo 2^ADDR_WIDTH.
- Issue condition: stream_active and occupancy+inflight < DEPTH and page check passes.
  - Page check: if PAGE_STOP=1 and next_fetch[ADDR_WIDTH-1:12] != page of last stream origin, then stream_active becomes 0 and nothing is issued.
- FSM states:
  - IDLE: if issue condition, then mem_req=1, mem_addr=next_fetch, go to ISSUE.
  - ISSUE: mem_req and mem_addr held stable until mem_ack.
    - On mem_ack: go to WAIT if not stale, else DROP. next_fetch advances by STRIDE_LINES*LB.
    - A miss, flush or reset-free restart while in ISSUE sets stale=1. The request is not withdrawn.
  - WAIT: on mem_rvalid, write mem_rdata to tail with its tag, tail++, occupancy++, go to IDLE. A miss or flush while in WAIT goes to DROP.
  - DROP: on mem_rvalid, discard data, clear stale, go to IDLE.
- Timing: mem_req may assert on the cycle after the IDLE decision. At most one request is in flight (inflight=1 in ISSUE/WAIT/DROP).
- Simultaneous events:
  - Hit-pop and fill in the same cycle: both apply; occupancy = old - popped + 1.
  - Miss and fill in the same cycle: the fill is discarded; the buffer ends empty.
  - A flush has priority over a lookup in the same cycle: lookup_hit is still computed from current contents, but all entries are cleared and stream_active=0.
- Wrap-around: head/tail wrap modulo DEPTH. Full is occupancy==DEPTH, and no issue occurs when full. Addresses wrap modulo 2^ADDR_WIDTH when PAGE_STOP=0.
- Reset asserted mid-transaction: state returns to IDLE immediately. Memory must also be reset; no response is expected afterwards.
- occupancy is registered; it never exceeds DEPTH and never underflows.

Test Plan:
1. Miss at 0x0000_1000, DEPTH=4 -> requests 0x1020, 0x1040, 0x1060, 0x1080 in order. Occupancy reaches 4, then mem_req stays 0.
2. Full buffer, probe 0x1044 -> lookup_hit=1 with line 0x1040 data. Next cycle occupancy=2, then a request for 0x10A0 issues.
3. Miss at 0x2000 while WAIT for 0x1060 -> the state goes to DROP. The 0x1060 rvalid is discarded; the next request is 0x2020 and occupancy=0 before it fills.
4. PAGE_STOP=1, miss at 0x0000_1FC0 -> 0x1FE0 is fetched, then no request for 0x2000 and stream_active=0.
5. Hit-pop of 1 entry and mem_rvalid in the same cycle at occupancy 3 -> occupancy stays 3 and the new tag is at the old tail.
6. rst low during ISSUE with mem_ack low -> mem_req=0, occupancy=0 and state IDLE asynchronously; lookup_hit=0 on the next probe.
